// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline definitions for the forwarding / hazard unit.
//   REG_W        register-address width
//   reg_addr_t   register-address type
//   md_state_t   mul/div sequencer states (IDLE, BUSY, DONE)
//   FWD_*        operand-select encodings (EX/MEM beats MEM/WB beats RF)
//   stage_match  true when a pipeline stage writes a given non-zero source
package fwd_hazard_unit_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // x0 is hard-wired zero, so a write to it never produces a usable value.
  function automatic logic stage_match(input logic regwrite,
                                       input reg_addr_t rd,
                                       input reg_addr_t src);
    return regwrite && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority forwarding select for a single source operand.
//   src           source register address
//   mem_rd/_regwrite  EX/MEM destination and write enable
//   wb_rd/_regwrite   MEM/WB destination and write enable
//   sel           FWD_MEM, FWD_WB or FWD_RF (EX/MEM has priority)
module fwd_match
  import fwd_hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwrite,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (stage_match(mem_regwrite, mem_rd, src)) begin
      sel = FWD_MEM;
    end else if (stage_match(wb_regwrite, wb_rd, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard-detection unit for a 5-stage pipeline with an
// iterative mul/div unit in EX.
//   clk, rst_n            clock, async active-low reset
//   mem_stall             cache stall freezing the whole pipeline
//   id_rs, id_use_br      ID sources; ID instruction resolves a branch/jalr
//   ex_rs, ex_rd, ex_*    ID/EX sources, destination and flags
//   mem_rd, mem_*         EX/MEM destination and flags
//   wb_rd, wb_regwrite    MEM/WB destination and write enable
//   ex_fwd_sel            EX operand select per source
//   id_fwd_sel            ID branch-operand select per source
//   stall_if, stall_id    hold PC and IF/ID
//   bubble_ex             insert a NOP into ID/EX
//   md_hold               hold EX/MEM inputs while mul/div iterates
//   bubble_cnt            saturating count of inserted bubbles
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int MD_LAT  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_stall,
  input  logic [NUM_SRC*REG_W-1:0] id_rs,
  input  logic                     id_use_br,
  input  logic [NUM_SRC*REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0]         ex_rd,
  input  logic                     ex_regwrite,
  input  logic                     ex_memread,
  input  logic                     ex_md,
  input  logic [REG_W-1:0]         mem_rd,
  input  logic                     mem_regwrite,
  input  logic                     mem_memread,
  input  logic [REG_W-1:0]         wb_rd,
  input  logic                     wb_regwrite,
  output logic [NUM_SRC*2-1:0]     ex_fwd_sel,
  output logic [NUM_SRC*2-1:0]     id_fwd_sel,
  output logic                     stall_if,
  output logic                     stall_id,
  output logic                     bubble_ex,
  output logic                     md_hold,
  output logic [CNT_W-1:0]         bubble_cnt
);

  // BUSY runs MD_LAT-1 cycles (cnt MD_LAT-2 .. 0) and DONE adds one more.
  localparam logic [7:0] CNT_LOAD = 8'(MD_LAT - 2);

  md_state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic [NUM_SRC*2-1:0] id_sel_raw;
  logic ex_hit, mem_hit, hazard;

  // ---------------------------------------------------------------------
  // Forwarding selects (ungated, valid in every FSM state)
  // ---------------------------------------------------------------------
  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_match u_ex_match (
        .src          (ex_rs[g*REG_W +: REG_W]),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (ex_fwd_sel[g*2 +: 2])
      );

      fwd_match u_id_match (
        .src          (id_rs[g*REG_W +: REG_W]),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (id_sel_raw[g*2 +: 2])
      );
    end
  endgenerate

  assign id_fwd_sel = id_use_br ? id_sel_raw : '0;

  // ---------------------------------------------------------------------
  // Hazard detection against the ID sources
  // ---------------------------------------------------------------------
  always_comb begin
    ex_hit  = 1'b0;
    mem_hit = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      ex_hit  = ex_hit  | stage_match(ex_regwrite,  ex_rd,  id_rs[s*REG_W +: REG_W]);
      mem_hit = mem_hit | stage_match(mem_regwrite, mem_rd, id_rs[s*REG_W +: REG_W]);
    end
  end

  assign hazard = (ex_memread && ex_hit)
               || (id_use_br && ex_hit)
               || (id_use_br && mem_memread && mem_hit)
               || ((state == BUSY) && ex_md && ex_hit);

  // ---------------------------------------------------------------------
  // Mul/div sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    md_hold   = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_stall && ex_md) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        md_hold = 1'b1;
        if (!mem_stall) begin
          if (cnt == '0) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
      end
      DONE: begin
        if (!mem_stall) begin
          if (ex_md) begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stalls are not masked by mem_stall; only the bubble (and its count) is.
  assign stall_if  = md_hold | hazard;
  assign stall_id  = md_hold | hazard;
  assign bubble_ex = !md_hold && hazard && !mem_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (bubble_ex && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int NUM_SRC = 2;
  localparam int MD_LAT  = 32;
  localparam int CNT_W   = 16;

  logic                 clk;
  logic                 rst_n;
  logic                 mem_stall;
  logic [NUM_SRC*5-1:0] id_rs;
  logic                 id_use_br;
  logic [NUM_SRC*5-1:0] ex_rs;
  logic [4:0]           ex_rd;
  logic                 ex_regwrite;
  logic                 ex_memread;
  logic                 ex_md;
  logic [4:0]           mem_rd;
  logic                 mem_regwrite;
  logic                 mem_memread;
  logic [4:0]           wb_rd;
  logic                 wb_regwrite;
  logic [NUM_SRC*2-1:0] ex_fwd_sel;
  logic [NUM_SRC*2-1:0] id_fwd_sel;
  logic                 stall_if;
  logic                 stall_id;
  logic                 bubble_ex;
  logic                 md_hold;
  logic [CNT_W-1:0]     bubble_cnt;

  int errors = 0;
  int checks = 0;

  fwd_hazard_unit #(
    .NUM_SRC (NUM_SRC),
    .MD_LAT  (MD_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_stall    (mem_stall),
    .id_rs        (id_rs),
    .id_use_br    (id_use_br),
    .ex_rs        (ex_rs),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_md        (ex_md),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .ex_fwd_sel   (ex_fwd_sel),
    .id_fwd_sel   (id_fwd_sel),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .bubble_ex    (bubble_ex),
    .md_hold      (md_hold),
    .bubble_cnt   (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    mem_stall    = 1'b0;
    id_rs        = '0;
    id_use_br    = 1'b0;
    ex_rs        = '0;
    ex_rd        = '0;
    ex_regwrite  = 1'b0;
    ex_memread   = 1'b0;
    ex_md        = 1'b0;
    mem_rd       = '0;
    mem_regwrite = 1'b0;
    mem_memread  = 1'b0;
    wb_rd        = '0;
    wb_regwrite  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a mul/div writing x4 with a dependent in ID; count md_hold cycles.
  // mem_stall is raised while span is in [stall_from, stall_from+5).
  task automatic md_run(input int stall_from, output int span, output logic held);
    clr();
    ex_md       = 1'b1;
    ex_regwrite = 1'b1;
    ex_rd       = 5'd4;
    id_rs[4:0]  = 5'd4;
    #1;
    check("md_idle_hold", 32'(md_hold), 32'd0);
    span = 0;
    held = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (!md_hold) break;
      span++;
      held = held & stall_if & stall_id & !bubble_ex;
      if (span == 10) begin
        mem_rd       = 5'd4;
        mem_regwrite = 1'b1;
        ex_rs[4:0]   = 5'd4;
        #1;
        check("fwd_busy", 32'(ex_fwd_sel[1:0]), 32'h2);
        mem_regwrite = 1'b0;
      end
      mem_stall = (span >= stall_from) && (span < stall_from + 5);
    end
    // DONE cycle: the mul/div result leaves EX
    clr();
  endtask

  int   span;
  logic held;

  initial begin
    clr();
    rst_n = 1'b0;
    #12;
    check("rst_cnt", 32'(bubble_cnt), 32'd0);
    check("rst_hold", 32'(md_hold), 32'd0);
    check("rst_stall", 32'(stall_if), 32'd0);
    check("rst_bubble", 32'(bubble_ex), 32'd0);
    rst_n = 1'b1;
    tick();

    // Forwarding priority and qualifiers
    mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1;
    ex_rs = {5'd9, 5'd5};
    #1;
    check("fwd_mem_prio", 32'(ex_fwd_sel[1:0]), 32'h2);
    check("fwd_nomatch", 32'(ex_fwd_sel[3:2]), 32'h0);
    check("id_nobr", 32'(id_fwd_sel), 32'h0);
    mem_rd = 5'd6;
    #1;
    check("fwd_wb", 32'(ex_fwd_sel[1:0]), 32'h1);
    mem_rd = 5'd0; wb_regwrite = 1'b0; ex_rs = '0;
    #1;
    check("fwd_rd0", 32'(ex_fwd_sel[1:0]), 32'h0);
    clr();
    id_use_br = 1'b1; id_rs = {5'd2, 5'd8};
    mem_rd = 5'd8; mem_regwrite = 1'b1; wb_rd = 5'd2; wb_regwrite = 1'b1;
    #1;
    check("id_br_sel", 32'(id_fwd_sel), 32'h6);
    tick();

    // Load-use stall
    clr();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7; id_rs[9:5] = 5'd7;
    #1;
    check("lu_stall_if", 32'(stall_if), 32'd1);
    check("lu_stall_id", 32'(stall_id), 32'd1);
    check("lu_bubble", 32'(bubble_ex), 32'd1);
    tick();
    clr();
    mem_rd = 5'd7; mem_memread = 1'b1; mem_regwrite = 1'b1; id_rs[9:5] = 5'd7;
    #1;
    check("lu_cnt", 32'(bubble_cnt), 32'd1);
    check("lu_clear", 32'(stall_if), 32'd0);
    tick();

    // Branch in ID depending on a load: two bubbles then MEM/WB forward
    clr();
    id_use_br = 1'b1; ex_rd = 5'd3; ex_memread = 1'b1; ex_regwrite = 1'b1; id_rs[4:0] = 5'd3;
    #1;
    check("br_bub1", 32'(bubble_ex), 32'd1);
    tick();
    clr();
    id_use_br = 1'b1; mem_rd = 5'd3; mem_memread = 1'b1; mem_regwrite = 1'b1; id_rs[4:0] = 5'd3;
    #1;
    check("br_bub2", 32'(bubble_ex), 32'd1);
    tick();
    clr();
    id_use_br = 1'b1; wb_rd = 5'd3; wb_regwrite = 1'b1; id_rs[4:0] = 5'd3;
    #1;
    check("br_go", 32'(stall_if), 32'd0);
    check("br_fwd_wb", 32'(id_fwd_sel[1:0]), 32'h1);
    check("br_cnt", 32'(bubble_cnt), 32'd3);
    tick();

    // mem_stall suppresses bubble but keeps stall
    clr();
    mem_stall = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd9; id_rs[4:0] = 5'd9;
    #1;
    check("ms_stall", 32'(stall_if), 32'd1);
    check("ms_bubble", 32'(bubble_ex), 32'd0);
    tick();
    check("ms_cnt", 32'(bubble_cnt), 32'd3);

    // Load to x0 never creates a hazard
    clr();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs[4:0] = 5'd0;
    #1;
    check("x0_nohaz", 32'(stall_if), 32'd0);
    tick();

    // Mul/div occupancy
    md_run(1000, span, held);
    check("md_span", 32'(span), 32'd31);
    check("md_stalled", 32'(held), 32'd1);
    check("md_done_free", 32'(stall_if), 32'd0);
    tick();
    check("md_back_idle", 32'(md_hold), 32'd0);
    check("md_cnt", 32'(bubble_cnt), 32'd3);

    // Mul/div with 5 stalled cycles
    md_run(5, span, held);
    check("mds_span", 32'(span), 32'd36);
    check("mds_stalled", 32'(held), 32'd1);
    tick();
    check("mds_cnt", 32'(bubble_cnt), 32'd3);

    // Reset at BUSY cycle 10
    clr();
    ex_md = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd4; id_rs[4:0] = 5'd4;
    for (int c = 0; c < 10; c++) tick();
    check("rb_busy", 32'(md_hold), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rb_hold", 32'(md_hold), 32'd0);
    check("rb_cnt", 32'(bubble_cnt), 32'd0);
    check("rb_stall", 32'(stall_if), 32'd0);
    ex_md = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    check("rb_idle", 32'(md_hold), 32'd0);

    // Counter restarts from zero
    clr();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd12; id_rs[9:5] = 5'd12;
    tick();
    check("rb_cnt_inc", 32'(bubble_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
